// File: rtl/match_alarm_pkg.sv
// Shared types and width helpers for the match alarm controller.
// The state enum is 2 bits wide; counter widths are derived from the timing parameters.
package match_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ALARM   = 2'd2,
        LOCKOUT = 2'd3
    } alarm_state_e;

    // A counter must hold n-1; never allow a zero-width vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_THRESHOLD   = 3;
    localparam int DEF_WINDOW      = 64;
    localparam int DEF_LOCK_CYCLES = 16;
    localparam int DEF_WIN_W       = cnt_width(DEF_WINDOW);
    localparam int DEF_LOCK_W      = cnt_width(DEF_LOCK_CYCLES);

endpackage

// File: rtl/match_alarm_ctrl_load_down_counter.sv
// Loadable down-counter that stops at zero; used for the event window and the lockout timer.
module load_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/match_alarm_ctrl.sv
// Turns detector match rising edges into events, raises an alarm when THRESHOLD events
// land inside a WINDOW-cycle window, then holds a timed lockout after acknowledge.
module match_alarm_ctrl
    import match_alarm_pkg::*;
#(
    parameter int THRESHOLD   = DEF_THRESHOLD,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match_in,
    input  logic             ack,
    output logic             alarm,
    output logic             irq,
    output logic             lockout,
    output logic             busy,
    output logic [7:0]       hit_count,
    output logic [CNT_W-1:0] event_total
);

    localparam int WIN_W  = cnt_width(WINDOW);
    localparam int LOCK_W = cnt_width(LOCK_CYCLES);
    localparam logic [7:0]        THR_V    = 8'(THRESHOLD);
    localparam logic [7:0]        THR_M1   = 8'(THRESHOLD - 1);
    localparam logic [WIN_W-1:0]  WIN_LD   = WIN_W'(WINDOW - 1);
    localparam logic [LOCK_W-1:0] LOCK_LD  = LOCK_W'(LOCK_CYCLES - 1);

    alarm_state_e state;
    logic match_q;
    logic evt;
    logic at_thr;
    logic win_zero;
    logic lock_zero;
    logic win_load;
    logic lock_load;

    assign evt    = match_in & ~match_q;
    assign at_thr = evt && (hit_count == THR_M1);

    // A below-threshold event on the last window cycle opens a fresh window.
    assign win_load  = ((state == IDLE) && evt) ||
                       ((state == ARMED) && evt && !at_thr && win_zero);
    assign lock_load = (state == ALARM) && ack;

    load_down_counter #(.WIDTH(WIN_W)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (WIN_LD),
        .en       (state == ARMED),
        .zero     (win_zero)
    );

    load_down_counter #(.WIDTH(LOCK_W)) u_lock_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .load_val (LOCK_LD),
        .en       (state == LOCKOUT),
        .zero     (lock_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            match_q     <= 1'b0;
            alarm       <= 1'b0;
            irq         <= 1'b0;
            lockout     <= 1'b0;
            busy        <= 1'b0;
            hit_count   <= '0;
            event_total <= '0;
        end else begin
            match_q <= match_in;
            irq     <= 1'b0;
            if (evt && (event_total != '1)) begin
                event_total <= event_total + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (evt) begin
                        state     <= ARMED;
                        hit_count <= 8'd1;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    if (at_thr) begin
                        state     <= ALARM;
                        hit_count <= THR_V;
                        alarm     <= 1'b1;
                        irq       <= 1'b1;
                    end else if (evt) begin
                        hit_count <= win_zero ? 8'd1 : hit_count + 8'd1;
                    end else if (win_zero) begin
                        state     <= IDLE;
                        hit_count <= '0;
                        busy      <= 1'b0;
                    end
                end
                ALARM: begin
                    if (ack) begin
                        state     <= LOCKOUT;
                        hit_count <= '0;
                        alarm     <= 1'b0;
                        lockout   <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (lock_zero) begin
                        state   <= IDLE;
                        lockout <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
